instruction_loader: RTL

Boot-time loader that sits directly upstream of the instruction RAM and drives its write port. It accepts a byte stream from the serial/storage front end over a valid/ready handshake, packs four bytes into one 32-bit instruction word, and writes consecutive words starting at a programmed base address. It reports busy/done/error to the control unit, which holds the processor in reset until `done`.

---
 rtl/galetron_loader_pkg.sv | 19 +
 rtl/instruction_loader_byte_packer.sv | 33 +++
 rtl/instruction_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/galetron_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// INSTRUCTION_LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum word.
package galetron_loader_pkg;

    localparam int IRAM_DEPTH      = 1501;
    localparam int IRAM_ADDR_WIDTH = 12;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        ST_CHECK   = 3'd3,
`endif
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first accepted byte lands in bits 31:24.
// word_ready pulses combinationally with the 4th accepted byte; clear restarts the word.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);
    import galetron_loader_pkg::*;

    logic [1:0]  byte_cnt;
    logic [31:0] shift_reg;

    assign word       = shift_reg;
    assign word_ready = take && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 32'd0;
        end else if (clear) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 32'd0;
        end else if (take) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= {shift_reg[23:0], byte_in};
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: packs a byte stream into 32-bit words and writes them to the instruction RAM.
// INSTRUCTION_LOADER_CHECKSUM_EN: a trailing XOR checksum word is compared before done.
//
// state      | meaning
// IDLE       | waiting for start; range and zero-length checks happen here
// COLLECT    | accepting bytes of the current word
// WRITE      | one-cycle RAM write of the assembled word
// CHECK      | accepting the 4 checksum bytes (checksum build only)
// FINISH     | done pulse, error if flagged
module instruction_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int IRAM_DEPTH = 1501
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] i_ram_writing_address,
    output logic [DATA_WIDTH-1:0] i_ram_input,
    output logic                  flag_write_i_ram,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import galetron_loader_pkg::*;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = IRAM_DEPTH[ADDR_WIDTH:0];

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, count_q, index_q;
    logic                  err_q;
    logic                  start_ok, zero_len, out_of_range;
    logic                  take, word_ready, csum_bad;
    logic [31:0]           word;

    assign start_ok     = (state == ST_IDLE) && start;
    assign zero_len     = (word_count == '0);
    // 13-bit sum so base+count cannot wrap past the limit unnoticed
    assign out_of_range = ({1'b0, base_address} + {1'b0, word_count}) > DEPTH_LIMIT;
    assign take         = byte_valid && byte_ready;

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .take       (take),
        .byte_in    (byte_in),
        .word       (word),
        .word_ready (word_ready)
    );

    assign i_ram_input           = word;
    assign i_ram_writing_address = addr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (zero_len || out_of_range) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (word_ready) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (index_q + 1'b1 == count_q) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_FINISH;
`endif
                end else begin
                    state_nxt = ST_COLLECT;
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (word_ready) begin
                    state_nxt = ST_FINISH;
                end
            end
`endif
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready       = 1'b0;
        flag_write_i_ram = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        case (state)
            ST_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                flag_write_i_ram = 1'b1;
                busy             = 1'b1;
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            ST_FINISH: begin
                done  = 1'b1;
                error = err_q || csum_bad;
            end
            default: ;
        endcase
    end

    // addr_q tracks base+index so the write address is a plain register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else if (start_ok) begin
            addr_q  <= base_address;
            count_q <= word_count;
            index_q <= '0;
            err_q   <= !zero_len && out_of_range;
        end else if (state == ST_WRITE) begin
            addr_q  <= addr_q + 1'b1;
            index_q <= index_q + 1'b1;
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
    logic        chk_q;

    // In FINISH the packer still holds the received checksum word
    assign csum_bad = chk_q && (word != csum_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= 32'd0;
            chk_q  <= 1'b0;
        end else if (start_ok) begin
            csum_q <= 32'd0;
            chk_q  <= 1'b0;
        end else begin
            if (state == ST_WRITE) begin
                csum_q <= csum_q ^ word;
            end
            if (state == ST_CHECK && word_ready) begin
                chk_q <= 1'b1;
            end
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

endmodule
